// File: rtl/bam_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bam_pkg : register map, field positions, FSM encoding, frame length. Rev 1.0
// ---------------------------------------------------------------------------
package bam_pkg;

  localparam logic [1:0] ADDR_CONFIG = 2'd0;
  localparam logic [1:0] ADDR_DUTY   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  localparam int CFG_ON_BIT     = 0;
  localparam int CFG_PSEL_LSB   = 1;
  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_FDONE_BIT = 1;
  localparam int STAT_FCNT_LSB  = 8;

  localparam int FRAME_TICKS = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } bam_state_e;

  // 2^n - 1: prescaler compare value and also the last slot index of bit n.
  function automatic logic [6:0] divide_by(input logic [2:0] n);
    logic [7:0] v;
    v = (8'd1 << n) - 8'd1;
    return v[6:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/bam_slot_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bam_slot_sequencer : bit/slot counters and frame-end detection. Rev 1.0
// ---------------------------------------------------------------------------
module bam_slot_sequencer
  import bam_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clear_i,
  input  logic       advance_i,
  output logic [2:0] bit_idx_o,
  output logic       frame_end_o
);

  logic [2:0] bit_idx_q, bit_idx_d;
  logic [6:0] slot_cnt_q, slot_cnt_d;
  logic       slot_done;

  assign slot_done   = (slot_cnt_q == divide_by(bit_idx_q));
  assign frame_end_o = advance_i & slot_done & (bit_idx_q == 3'd7);
  assign bit_idx_o   = bit_idx_q;

  // bit_idx wraps 7 -> 0 naturally on the frame-end tick.
  always_comb begin
    bit_idx_d  = bit_idx_q;
    slot_cnt_d = slot_cnt_q;
    if (clear_i) begin
      bit_idx_d  = 3'd0;
      slot_cnt_d = 7'd0;
    end else if (advance_i) begin
      if (slot_done) begin
        slot_cnt_d = 7'd0;
        bit_idx_d  = bit_idx_q + 3'd1;
      end else begin
        slot_cnt_d = slot_cnt_q + 7'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bit_idx_q  <= 3'd0;
      slot_cnt_q <= 7'd0;
    end else begin
      bit_idx_q  <= bit_idx_d;
      slot_cnt_q <= slot_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bam_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bam_controller : bus registers, IDLE/LOAD/RUN FSM and BAM output. Rev 1.0
// ---------------------------------------------------------------------------
module bam_controller
  import bam_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_arst,
  input  logic        i_we,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  input  logic        i_tick,
  output logic        o_on,
  output logic [6:0]  o_divide_by,
  output logic        o_bam,
  output logic        o_frame_irq
);

  bam_state_e state_q, state_d;
  logic       on_q;
  logic [2:0] psel_q, psel_act_q;
  logic [7:0] duty_q, shadow_q, fcnt_q;
  logic       fdone_q;

  logic       busy, cfg_we, duty_we, fdone_clr;
  logic       seq_clear, seq_advance, frame_end;
  logic [2:0] bit_idx;
  logic       wdata_unused;

  assign cfg_we      = i_we & (i_addr == ADDR_CONFIG);
  assign duty_we     = i_we & (i_addr == ADDR_DUTY);
  assign fdone_clr   = i_we & (i_addr == ADDR_STATUS) & i_wdata[STAT_FDONE_BIT];
  assign seq_clear   = (state_q != ST_RUN);
  assign seq_advance = (state_q == ST_RUN) & i_tick;
  assign wdata_unused = ^i_wdata[31:8];

  bam_slot_sequencer u_seq (
    .clk_i       (i_clk),
    .rst_i       (i_arst),
    .clear_i     (seq_clear),
    .advance_i   (seq_advance),
    .bit_idx_o   (bit_idx),
    .frame_end_o (frame_end)
  );

  always_ff @(posedge i_clk) begin
    if (i_arst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (on_q) state_d = ST_LOAD;
      ST_LOAD: state_d = on_q ? ST_RUN : ST_IDLE;
      ST_RUN:  if (!on_q) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are forced low while reset is asserted, not just after it.
  always_comb begin
    busy        = (state_q != ST_IDLE);
    o_on        = ~i_arst & on_q;
    o_divide_by = i_arst ? 7'd0 : divide_by(psel_act_q);
    o_bam       = ~i_arst & (state_q == ST_RUN) & shadow_q[bit_idx];
    o_frame_irq = ~i_arst & frame_end;
  end

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      on_q       <= 1'b0;
      psel_q     <= 3'd0;
      duty_q     <= 8'd0;
      shadow_q   <= 8'd0;
      psel_act_q <= 3'd0;
      fcnt_q     <= 8'd0;
      fdone_q    <= 1'b0;
    end else begin
      if (cfg_we) begin
        on_q   <= i_wdata[CFG_ON_BIT];
        psel_q <= i_wdata[CFG_PSEL_LSB +: 3];
      end
      if (duty_we) duty_q <= i_wdata[7:0];
      if ((state_q == ST_LOAD) || frame_end) begin
        shadow_q   <= duty_q;
        psel_act_q <= psel_q;
      end
      if (frame_end) begin
        fcnt_q  <= fcnt_q + 8'd1;
        fdone_q <= 1'b1;
      end else if (fdone_clr) begin
        fdone_q <= 1'b0;
      end
    end
  end

  always_comb begin
    o_rdata = 32'd0;
    case (i_addr)
      ADDR_CONFIG: begin
        o_rdata[CFG_ON_BIT]        = on_q;
        o_rdata[CFG_PSEL_LSB +: 3] = psel_q;
      end
      ADDR_DUTY:   o_rdata[7:0] = duty_q;
      ADDR_STATUS: begin
        o_rdata[STAT_BUSY_BIT]      = busy;
        o_rdata[STAT_FDONE_BIT]     = fdone_q;
        o_rdata[STAT_FCNT_LSB +: 8] = fcnt_q;
      end
      ADDR_RSVD:   o_rdata = 32'd0;
      default:     o_rdata = 32'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: doc/bam_controller.md
BAM_CONTROLLER -- requirements
Module: bam_controller

Interface
REQ-001 SHALL have exactly one clock; reset is synchronous and active-high.
REQ-002 SHALL expose: i_clk  in  1  system clock (CONFIG registers and sequencing).
REQ-003 SHALL expose: i_arst  in  1  synchronous active-high reset, sampled on rising i_clk only.
REQ-004 SHALL expose: i_we  in  1  bus write strobe from the MIPS datapath, one cycle per write.
REQ-005 SHALL expose: i_addr  in  2  register select: 0 CONFIG, 1 DUTY, 2 STATUS, 3 reserved.
REQ-006 SHALL expose: i_wdata  in  32  bus write data.
REQ-007 SHALL expose: o_rdata  out  32  combinational read data for i_addr.
REQ-008 SHALL expose: i_tick  in  1  clock-enable pulse from the prescaler, one cycle wide.
REQ-009 SHALL expose: o_on  out  1  prescaler enable, equal to CONFIG.ON.
REQ-010 SHALL expose: o_divide_by  out  7  prescaler compare value.
REQ-011 SHALL expose: o_bam  out  1  BAM output.
REQ-012 SHALL expose: o_frame_irq  out  1  one-cycle pulse at each frame end.

Function
REQ-013 SHALL decode CONFIG as: bit0 ON; bits[3:1] PSEL (0..7); all other bits read 0.
REQ-014 SHALL decode DUTY as bits[7:0], read/write; all other bits read 0.
REQ-015 SHALL decode STATUS as: bit0 BUSY (RO); bit1 FDONE (sticky, write-1-to-clear); bits[15:8] FCNT (RO, wraps 255->0); all other bits read 0.
REQ-016 SHALL read address 3 as 0 and SHALL ignore writes to it.
REQ-017 SHALL drive o_divide_by = (1<<PSEL_active)-1, so the tick period is 2^PSEL_active clocks (PSEL 0 -> 0, PSEL 7 -> 127).
REQ-018 SHALL load PSEL_active from CONFIG.PSEL only in LOAD or at a frame end, so prescale changes never occur mid-frame.
REQ-019 SHALL implement FSM states IDLE, LOAD, RUN.
REQ-020 IDLE -> LOAD SHALL occur on the cycle after ON becomes 1; LOAD lasts exactly one cycle, then moves to RUN.
REQ-021 LOAD SHALL copy DUTY into the duty shadow, copy PSEL into PSEL_active, and clear bit_idx (3b) and slot_cnt (7b).
REQ-022 In RUN, o_bam SHALL equal shadow[bit_idx] with registered timing; in IDLE and LOAD, o_bam SHALL be 0.
REQ-023 In RUN on i_tick: if slot_cnt == 2^bit_idx - 1, then slot_cnt <= 0 and bit_idx advances; otherwise slot_cnt increments.
REQ-024 When i_tick ends slot 7 (bit_idx==7 and slot_cnt==127), the block SHALL perform a frame end in one cycle: bit_idx <= 0, shadow <= DUTY, PSEL_active <= PSEL, FCNT increments, FDONE set, o_frame_irq = 1.
REQ-025 A frame SHALL be exactly 255 ticks; DUTY=d SHALL yield d high ticks per frame.
REQ-026 Writes to DUTY during RUN SHALL take effect only at the next frame end.
REQ-027 When ON is 0, the FSM SHALL go to IDLE on the next cycle from any state, clearing bit_idx and slot_cnt; FCNT and FDONE are retained.
REQ-028 i_tick SHALL be ignored outside RUN.
REQ-029 If a FDONE set and a write-1-clear occur in the same cycle, set SHALL win.
REQ-030 BUSY SHALL be 1 in LOAD and RUN, and 0 in IDLE.

Reset
REQ-031 On i_arst, the block SHALL clear CONFIG, DUTY, shadow, PSEL_active, FCNT, FDONE, bit_idx and slot_cnt, and SHALL set the state to IDLE.
REQ-032 During and after reset, o_on=0, o_divide_by=0, o_bam=0 and o_frame_irq=0.
REQ-033 Reset SHALL take priority over a simultaneous bus write.
REQ-034 Reset mid-frame SHALL abort the frame with no o_frame_irq.

Structure
REQ-035 The shared package bam_pkg SHALL hold: register address constants, CONFIG/STATUS field positions, FSM state encoding, and frame length 255.
REQ-036 Slot/bit counting (bit_idx, slot_cnt, frame-end detect) SHALL live in sub-module bam_slot_sequencer; register file and FSM stay in the top level.

Verification
REQ-037 Reset with i_we=1 asserted -> all registers read 0, o_bam=0, and the write is lost.
REQ-038 DUTY=0x01, PSEL=0, ON=1, i_tick held 1 -> o_bam high exactly 1 of every 255 ticks, with o_frame_irq every 255 cycles.
REQ-039 DUTY=0xFF -> o_bam constantly 1 in RUN; DUTY=0x00 -> o_bam constantly 0; FCNT wraps 255->0 after 256 frames.
REQ-040 DUTY written 0x80->0x0F mid-frame -> the current frame completes with pattern 0x80, and the next frame uses 0x0F.
REQ-041 PSEL written 2->7 mid-frame -> o_divide_by stays 3 until frame end, then becomes 127.
REQ-042 ON cleared at bit_idx=5 -> IDLE next cycle with o_bam=0; FDONE write-1 in the same cycle as frame end -> FDONE stays 1.
